// File: rtl/seven_segment_scan_controller.sv
// Scans an N-digit seven-segment display through one shared decoder, with double-buffered frame-aligned loads.
// Latency: the decoder is combinational, so segments and digit enables change together; a load shows from the next frame.
// Backpressure: load_ready drops while a value is pending and rises again when that value commits.
module seven_segment_scan_controller #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  lz_blank,
  input  logic                  load_valid,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic                  load_ready,
  output logic [3:0]            dec_nibble,
  input  logic [6:0]            seg_in,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done
);

  // Prescaler needs at least one bit even when every cycle is a slot.
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]          presc;
  logic [IW-1:0]          idx;
  logic [4*DIGITS-1:0]    active_buf;
  logic [4*DIGITS-1:0]    pend_buf;
  logic                   pend_full;

  logic                   tick;
  logic                   boundary;
  logic                   commit_now;
  logic                   accept;
  logic [DIGITS-1:0]      upper_zero;
  logic                   blank_cur;

  assign tick     = enable && (presc == PRESC_LAST);
  assign boundary = tick && (idx == IDX_LAST);

  // A pending value swaps in at a frame boundary, or immediately when the display is off
  // since there is no frame in flight to tear.
  assign commit_now = pend_full && (enable ? boundary : 1'b1);

  // Commit and accept are mutually exclusive: accept needs pend_full low, commit needs it high.
  assign accept     = load_valid && !pend_full;
  assign load_ready = !pend_full;

  // Slot prescaler and digit index; disabling parks the scan at the start of digit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (!enable) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= boundary ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Double buffer: capture into pend_buf on handshake, move to active_buf on commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_buf <= '0;
      pend_buf   <= '0;
      pend_full  <= 1'b0;
    end else if (commit_now) begin
      active_buf <= pend_buf;
      pend_full  <= 1'b0;
    end else if (accept) begin
      pend_buf   <= load_data;
      pend_full  <= 1'b1;
    end
  end

  // upper_zero[k] is set when digits k..DIGITS-1 of the active value are all zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[DIGITS-1] = (active_buf[4*(DIGITS-1) +: 4] == 4'h0);
    for (int k = DIGITS - 2; k >= 0; k--) begin
      upper_zero[k] = upper_zero[k+1] && (active_buf[4*k +: 4] == 4'h0);
    end
  end

  // Select the current digit's nibble, enable line and leading-zero blank; digit 0 is never blanked.
  always_comb begin
    dec_nibble = 4'h0;
    digit_sel  = '0;
    blank_cur  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        dec_nibble   = active_buf[4*k +: 4];
        digit_sel[k] = enable;
        if (k != 0) begin
          blank_cur = lz_blank && upper_zero[k];
        end
      end
    end
  end

  assign seg_out    = (enable && !blank_cur) ? seg_in : 7'b0;
  assign frame_done = boundary;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Randomized plus directed stimulus for the scan controller, scored against a cycle-count reference model.
// Latency: expectations are queued per cycle and compared on the following falling edge.
// Backpressure: the source holds each offered value until the model reports it accepted.
module tb_seven_segment_scan_controller;

  localparam int D  = 4;
  localparam int S  = 4;
  localparam int FR = D * S;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        lz_blank;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  dec_nibble;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic [3:0]  digit_sel;
  logic        frame_done;

  always #5 clk = ~clk;

  // Ordinary hex font standing in for the external decoder.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
    endcase
  endfunction

  assign seg_in = hex7(dec_nibble);

  seven_segment_scan_controller #(.DIGITS(D), .SCAN_DIV(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .lz_blank   (lz_blank),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .dec_nibble (dec_nibble),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic       rdy;
    logic [3:0] nib;
    logic [6:0] seg;
    logic [3:0] sel;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;

  // Reference model: m_t counts enabled cycles since the scan last restarted.
  int          m_t;
  logic [15:0] m_shown;
  logic [15:0] m_pend[$];
  bit          m_accept;

  bit          offer;
  logic [15:0] offer_data;
  bit          cur_en;
  bit          cur_lz;

  function automatic exp_t expect_now(input bit en, input bit lz);
    exp_t        e;
    int          dg;
    logic [15:0] up;
    bit          blank;
    dg    = (m_t / S) % D;
    up    = m_shown >> (4 * dg);
    blank = lz && (dg != 0) && (up == 16'h0);
    e.rdy = (m_pend.size() == 0);
    e.nib = up[3:0];
    e.sel = en ? 4'(1 << dg) : 4'h0;
    e.seg = (en && !blank) ? hex7(up[3:0]) : 7'h0;
    e.fd  = en && ((m_t % FR) == FR - 1);
    return e;
  endfunction

  task automatic model_edge(input bit r, input bit en, input bit lv, input logic [15:0] ld);
    bit bnd;
    bit had;
    m_accept = 1'b0;
    if (!r) begin
      m_t     = 0;
      m_shown = 16'h0;
      m_pend.delete();
    end else begin
      bnd      = en && ((m_t % FR) == FR - 1);
      had      = (m_pend.size() != 0);
      m_accept = lv && !had;
      m_t      = en ? m_t + 1 : 0;
      if (had && (!en || bnd)) m_shown = m_pend.pop_front();
      if (m_accept) m_pend.push_back(ld);
    end
  endtask

  // One clock of stimulus: drive, queue the expectation, advance the model at the edge.
  task automatic step(input bit r);
    rst_n      = r;
    enable     = cur_en;
    lz_blank   = cur_lz;
    load_valid = offer;
    load_data  = offer ? offer_data : 16'($urandom);
    exp_q.push_back(expect_now(cur_en, cur_lz));
    @(posedge clk);
    model_edge(r, cur_en, offer, load_data);
    if (m_accept) offer = 1'b0;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic do_reset();
    step(1'b0);
    step(1'b0);
  endtask

  task automatic offer_val(input logic [15:0] v);
    offer      = 1'b1;
    offer_data = v;
  endtask

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
  endtask

  // Monitor: compare every output against the expectation queued for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("load_ready", 7'(load_ready), 7'(mon_e.rdy));
      chk("dec_nibble", 7'(dec_nibble), 7'(mon_e.nib));
      chk("seg_out",    seg_out,        mon_e.seg);
      chk("digit_sel",  7'(digit_sel),  7'(mon_e.sel));
      chk("frame_done", 7'(frame_done), 7'(mon_e.fd));
    end
  end

  initial begin
    offer  = 1'b0;
    cur_en = 1'b1;
    cur_lz = 1'b0;
    // First reset edge is unchecked: DUT state is unknown before it.
    rst_n      = 1'b0;
    enable     = 1'b1;
    lz_blank   = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0;
    @(posedge clk);
    model_edge(1'b0, 1'b1, 1'b0, 16'h0);
    #1;

    // Scan timing and a frame-aligned load.
    do_reset();
    run(2);
    offer_val(16'h1234);
    run(46);

    // Back-to-back loads: second is held off until the first commits.
    offer_val(16'hAAAA);
    run(1);
    offer_val(16'h5555);
    run(48);

    // Load arriving on the boundary cycle waits for the next boundary.
    do_reset();
    run(15);
    offer_val(16'h00F0);
    run(48);

    // Leading-zero blanking, then without it.
    do_reset();
    cur_lz = 1'b1;
    offer_val(16'h0070);
    run(40);
    cur_lz = 1'b0;
    run(16);

    // Disable during digit 2, then re-enable.
    do_reset();
    run(9);
    cur_en = 1'b0;
    run(3);
    cur_en = 1'b1;
    run(20);

    // Load while disabled commits at once.
    cur_en = 1'b0;
    offer_val(16'h9801);
    run(4);
    cur_en = 1'b1;
    run(20);

    // Reset while a value is pending.
    offer_val(16'hBEEF);
    run(2);
    do_reset();
    run(20);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(99) < 3) cur_en = !cur_en;
      if ($urandom_range(99) < 5) cur_lz = !cur_lz;
      if (!offer && $urandom_range(99) < 25)
        offer_val(16'($urandom) >> (4 * $urandom_range(3)));
      step(($urandom_range(999) < 5) ? 1'b0 : 1'b1);
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan_controller.md
Name: seven_segment_scan_controller

Overview:
Time-multiplexed scan controller for an N-digit common-cathode seven-segment display. One combinational seven-segment decoder (4-bit hex nibble in, 7-bit segments out) is shared across all digits. The controller selects one digit per scan slot and presents that digit's nibble to the decoder. It gates the decoder's segment output for blanking and drives the one-hot digit enables. New display values arrive over a valid/ready handshake and are double-buffered, so a value only takes effect at a frame boundary and no frame ever mixes old and new digits.

Parameters:
DIGITS, 4, number of display digits (range 2..8); display value width is 4*DIGITS bits.
SCAN_DIV, 50000, clock cycles per digit slot (minimum 1); prescaler width is clog2(SCAN_DIV), minimum 1 bit.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
enable  input  1  scan enable; low turns the display off and holds the scan at digit 0.
lz_blank  input  1  high enables leading-zero blanking.
load_valid  input  1  new display value offered.
load_data  input  4*DIGITS  display value; digit k is bits [4k+3:4k], and digit 0 is least significant.
load_ready  output  1  controller can accept a value.
dec_nibble  output  4  nibble driven into the shared decoder's input.
seg_in  input  7  decoder segment output fed back to the controller.
seg_out  output  7  segments to pads; active-high.
digit_sel  output  DIGITS  one-hot digit enables; active-high.
frame_done  output  1  one-cycle pulse on the last cycle of each full frame.

Behaviour:
- State registers:
  - presc: 0..SCAN_DIV-1.
  - idx: 0..DIGITS-1.
  - active_buf: 4*DIGITS bits.
  - pend_buf: 4*DIGITS bits.
  - pend_full: 1 bit.
- Reset (rst_n=0 at an edge): presc=0, idx=0, active_buf=0, pend_buf=0, pend_full=0. Any pending value is discarded, including on reset mid-frame or mid-handshake.
- Output values while in reset and immediately after it: load_ready=1, dec_nibble=0, frame_done=0. digit_sel is 0 if enable=0, otherwise 1 (digit 0 selected). seg_out follows the blanking rules below.
- tick = enable & (presc==SCAN_DIV-1). boundary = tick & (idx==DIGITS-1).
- Prescaler and digit counter when enable=1:
  - presc increments each cycle and wraps to 0 on tick.
  - On tick, idx increments; on boundary, idx wraps to 0.
  - Each digit is shown for exactly SCAN_DIV cycles; one frame is DIGITS*SCAN_DIV cycles.
- enable=0: presc and idx are forced to 0 on the next edge. digit_sel=0, seg_out=0, frame_done=0.
- Handshake:
  - load_ready = ~pend_full (combinational).
  - A transfer occurs on an edge where load_valid & load_ready: pend_buf<=load_data, pend_full<=1.
  - load_data is ignored when load_ready=0. The source must hold load_valid until accepted.
- Commit:
  - If enable=1: on a boundary edge with pend_full=1 at the start of the cycle, active_buf<=pend_buf and pend_full<=0. The new value is first visible on digit 0 of the next frame.
  - If enable=0: a pending value commits on the first edge where pend_full=1.
- Simultaneous events:
  - A transfer in the same cycle as a boundary, with pend_full=0 beforehand, is captured into pend_buf and commits at the following boundary, not the current one.
  - A commit and a new transfer cannot coincide, because load_ready=0 while pend_full=1.
- Outputs, all combinational from registered state plus enable, lz_blank and seg_in:
  - dec_nibble = active_buf digit[idx].
  - digit_sel = enable ? (1<<idx) : 0.
  - blank_cur = lz_blank & (idx!=0) & (digits idx..DIGITS-1 of active_buf are all 0). Digit 0 is never blanked.
  - seg_out = (enable & ~blank_cur) ? seg_in : 7'b0.
  - frame_done = boundary.
- Decoder latency is zero (combinational), so seg_out is valid in the same cycle as digit_sel.

Test Plan:
(DIGITS=4, SCAN_DIV=4; cycle 0 is the first edge with rst_n=1 and enable=1.)
1. Scan timing: reset, then enable=1 with no load. digit_sel is 0001 for cycles 0-3, 0010 for 4-7, 0100 for 8-11, 1000 for 12-15, then 0001 again. frame_done=1 only in cycles 15, 31, and so on. dec_nibble=0 throughout.
2. Frame-aligned load: at cycle 2, load_valid=1 with load_data=16'h1234. load_ready drops after cycle 2. dec_nibble stays 0 through cycle 15. From cycle 16, dec_nibble is 4,3,2,1 on digits 0..3. load_ready=1 again from cycle 16.
3. Back-pressure: offer 16'hAAAA then 16'h5555 back-to-back in one frame. The second is held off (load_ready=0) until after the boundary. Frame 2 shows AAAA and frame 3 shows 5555; no frame mixes digits.
4. Boundary collision: offer 16'h00F0 during cycle 15, when boundary=1 and pend_full=0. Frame 2 (cycles 16-31) still shows 0000; frame 3 shows 00F0.
5. Leading-zero blanking: active value 16'h0070 with lz_blank=1. seg_out=0 while digit_sel is 1000 or 0100. seg_out=seg_in on digit 1 (shows 7) and on digit 0 (shows 0). With lz_blank=0, all four digits show seg_in.
6. Enable and reset mid-operation:
   - Drop enable during the digit 2 slot: the next cycle has digit_sel=0 and seg_out=0. On re-enable, the scan restarts at digit 0 with a full SCAN_DIV slot.
   - Assert rst_n=0 while pend_full=1: pend_full and active_buf clear, and load_ready=1 after the reset edge.
